// File: rtl/cmp_iter.sv
// Iterative RISC-V branch comparator: CHUNK bits per clock, MSB chunk first.
// Optional macro CMP_EARLY_EXIT_EN ends the run on the first differing chunk.
module cmp_iter #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] rs1_d,
    input  logic [XLEN-1:0] rs2_d,
    input  logic [2:0]      cmp_op,
    output logic            ready_o,
    output logic            valid_o,
    output logic            b
);

    localparam int N    = XLEN / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_GE  = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_GEU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [XLEN-1:0]   opA_q;
    logic [XLEN-1:0]   opB_q;
    logic [2:0]        op_q;
    logic              eq_q;
    logic              lt_q;

    logic [CHUNK-1:0]  chunkA;
    logic [CHUNK-1:0]  chunkB;
    logic              chunkDiffer;
    logic              eq_d;
    logic              lt_d;
    logic              taken_d;
    logic              opValid;
    logic              lastChunk;
    logic              leaveRun;
    logic [XLEN-1:0]   signMask;

    // Operands shift left each RUN cycle, so the current chunk is always on top.
    assign chunkA      = opA_q[XLEN-1 -: CHUNK];
    assign chunkB      = opB_q[XLEN-1 -: CHUNK];
    assign chunkDiffer = (chunkA != chunkB);
    assign opValid     = (op_q <= OP_GEU);
    assign lastChunk   = (idx_q == IDXW'(N - 1));

    // Flipping both sign bits turns a signed compare into an unsigned one.
    assign signMask = ((cmp_op == OP_LT) || (cmp_op == OP_GE))
                      ? (XLEN'(1) << (XLEN - 1)) : '0;

    always_comb begin
        eq_d = eq_q;
        lt_d = lt_q;
        if (eq_q && chunkDiffer) begin
            eq_d = 1'b0;
            lt_d = (chunkA < chunkB);
        end
    end

    always_comb begin
        taken_d = 1'b0;
        case (op_q)
            OP_EQ:          taken_d = eq_d;
            OP_NE:          taken_d = !eq_d;
            OP_LT, OP_LTU:  taken_d = lt_d;
            OP_GE, OP_GEU:  taken_d = !lt_d;
            default:        taken_d = 1'b0;
        endcase
    end

    // An invalid op spends one RUN cycle and leaves with b=0, giving it latency 1.
`ifdef CMP_EARLY_EXIT_EN
    assign leaveRun = lastChunk || !opValid || (eq_q && chunkDiffer);
`else
    assign leaveRun = lastChunk || !opValid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            op_q    <= OP_EQ;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            b       <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        opA_q   <= rs1_d ^ signMask;
                        opB_q   <= rs2_d ^ signMask;
                        op_q    <= cmp_op;
                        idx_q   <= '0;
                        eq_q    <= 1'b1;
                        lt_q    <= 1'b0;
                        state_q <= RUN;
                        ready_o <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_o <= 1'b1;
                    end
                end
                RUN: begin
                    eq_q  <= eq_d;
                    lt_q  <= lt_d;
                    opA_q <= opA_q << CHUNK;
                    opB_q <= opB_q << CHUNK;
                    if (leaveRun) begin
                        state_q <= DONE;
                        valid_o <= 1'b1;
                        ready_o <= 1'b1;
                        b       <= taken_d;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
